// File: rtl/in_port_ctrl_if.sv
// Bundle of the source-side and CPU-side signals of the input-port controller.
// Latency: none (wires only).
// Backpressure: ext_ready is the source's only flow control; the source holds ext_data while it is low.
// Ports: ext_data/ext_valid/ext_ready (source push), in_rd/input_port (CPU IN),
//        intr_en/interrupt/intr_ack (interrupt), count/rd_err (status).
interface in_port_ctrl_if #(
    parameter int DEPTH = 4
);
    logic [7:0]             ext_data;
    logic                   ext_valid;
    logic                   ext_ready;
    logic                   in_rd;
    logic [7:0]             input_port;
    logic                   intr_en;
    logic                   interrupt;
    logic                   intr_ack;
    logic [$clog2(DEPTH):0] count;
    logic                   rd_err;

    // Controller side
    modport slave (
        input  ext_data, ext_valid, in_rd, intr_en, intr_ack,
        output ext_ready, input_port, interrupt, count, rd_err
    );

    // Source/CPU side
    modport master (
        output ext_data, ext_valid, in_rd, intr_en, intr_ack,
        input  ext_ready, input_port, interrupt, count, rd_err
    );
endinterface

// File: rtl/in_port_ctrl.sv
// Input-port controller: byte FIFO between an external source and the CPU IN port, with interrupt + hold-off.
// Latency: byte pushed at edge N is on input_port after edge N; interrupt rises after edge N+1.
// Backpressure: ext_ready = !full; a held byte is never dropped. Pop on empty is ignored and sets sticky rd_err.
// Ports: clk, reset (async active-low), bus (in_port_ctrl_if.slave).
module in_port_ctrl #(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 8
) (
    input  logic            clk,
    input  logic            reset,
    in_port_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          rd_err_q;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          intr_q;

    logic full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.ext_valid && !full;
    assign pop   = bus.in_rd && !empty;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left out of reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.ext_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (bus.in_rd && empty) rd_err_q <= 1'b1;
        end
    end

    // Interrupt FSM. DRAIN looks at next-cycle occupancy so a pop that empties
    // the FIFO starts the hold-off on that same edge.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (bus.intr_en && !empty) state_d = REQ;
            end
            REQ: begin
                if (bus.intr_ack)      state_d = DRAIN;
                else if (!bus.intr_en) state_d = IDLE;
            end
            DRAIN: begin
                if (count_d == '0) begin
                    if (HOLDOFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HW'(HOLDOFF);
                    end
                end
            end
            HOLD: begin
                hold_d = hold_q - HW'(1);
                if (hold_q <= HW'(1)) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            intr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            intr_q  <= (state_d == REQ);
        end
    end

    assign bus.ext_ready  = !full;
    assign bus.input_port = empty ? 8'h00 : mem[rd_ptr_q];
    assign bus.interrupt  = intr_q;
    assign bus.count      = count_q;
    assign bus.rd_err     = rd_err_q;
endmodule

// File: tb/tb_in_port_ctrl.sv
// Directed bench for in_port_ctrl (DEPTH=4, HOLDOFF=8).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench holds ext_valid/ext_data while ext_ready is low, like a real source.
module tb_in_port_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    in_port_ctrl_if #(.DEPTH(4)) bus ();

    in_port_ctrl #(.DEPTH(4), .HOLDOFF(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       rd;
        logic       exp_rdy;
        logic [7:0] exp_port;
        int         exp_cnt;
        logic       exp_err;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic vld, input logic [7:0] dat, input logic rd);
        bus.ext_valid = vld;
        bus.ext_data  = dat;
        bus.in_rd     = rd;
    endtask

    initial begin
        //          vld   dat    rd    rdy   port   cnt err
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1, 1'b0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 2, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0, 1'b0};
        vecs[4]  = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1, 1'b0};
        vecs[5]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 2, 1'b0};
        vecs[6]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 3, 1'b0};
        vecs[7]  = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h01, 4, 1'b0};
        vecs[8]  = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h01, 4, 1'b0}; // full: held, not taken
        vecs[9]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h02, 3, 1'b0}; // full: pop only
        vecs[10] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h02, 4, 1'b0}; // 05 accepted, wr_ptr wrapped
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 3, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 2, 1'b0};
        vecs[13] = '{1'b1, 8'h06, 1'b1, 1'b1, 8'h05, 2, 1'b0}; // push+pop at 2
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0, 1'b1}; // read while empty
        vecs[17] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1, 1'b1}; // empty: push only
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0, 1'b1}; // rd_err sticky

        // Reset held with a pending byte
        set_in(1'b1, 8'hAA, 1'b0);
        bus.intr_en  = 1'b0;
        bus.intr_ack = 1'b0;
        step();
        step();
        chk("rst_ready", int'(bus.ext_ready), 1);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_port", int'(bus.input_port), 8'h00);
        chk("rst_intr", int'(bus.interrupt), 0);
        chk("rst_rderr", int'(bus.rd_err), 0);

        // Table: FIFO datapath with interrupts disabled
        set_in(vecs[0].vld, vecs[0].dat, vecs[0].rd);
        reset = 1'b1;
        for (int i = 0; i < 19; i++) begin
            set_in(vecs[i].vld, vecs[i].dat, vecs[i].rd);
            step();
            chk($sformatf("v%0d_ready", i), int'(bus.ext_ready), int'(vecs[i].exp_rdy));
            chk($sformatf("v%0d_port", i), int'(bus.input_port), int'(vecs[i].exp_port));
            chk($sformatf("v%0d_count", i), int'(bus.count), vecs[i].exp_cnt);
            chk($sformatf("v%0d_rderr", i), int'(bus.rd_err), int'(vecs[i].exp_err));
            chk($sformatf("v%0d_intr", i), int'(bus.interrupt), 0);
        end

        // Interrupt flow: push 3C at edge N, interrupt after N+1
        bus.intr_en = 1'b1;
        set_in(1'b1, 8'h3C, 1'b0);
        step();
        chk("irq_push_count", int'(bus.count), 1);
        chk("irq_n", int'(bus.interrupt), 0);
        set_in(1'b0, 8'h00, 1'b0);
        step();
        chk("irq_n1", int'(bus.interrupt), 1);
        bus.intr_ack = 1'b1;
        step();
        bus.intr_ack = 1'b0;
        chk("irq_ack", int'(bus.interrupt), 0);
        set_in(1'b1, 8'h41, 1'b0);
        step();
        chk("drain_push1", int'(bus.interrupt), 0);
        set_in(1'b1, 8'h42, 1'b0);
        step();
        chk("drain_push2", int'(bus.interrupt), 0);
        chk("drain_count", int'(bus.count), 3);
        set_in(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("drain_pop%0d", i), int'(bus.interrupt), 0);
        end
        chk("drain_empty", int'(bus.count), 0);
        // FIFO emptied at edge M; hold-off runs edges M+1..M+8
        set_in(1'b0, 8'h00, 1'b0);
        step();
        chk("hold_c1", int'(bus.interrupt), 0);
        step();
        chk("hold_c2", int'(bus.interrupt), 0);
        set_in(1'b1, 8'h55, 1'b0);
        step();
        set_in(1'b0, 8'h00, 1'b0);
        chk("hold_c3_push", int'(bus.count), 1);
        chk("hold_c3", int'(bus.interrupt), 0);
        for (int c = 4; c <= 8; c++) begin
            step();
            chk($sformatf("hold_c%0d", c), int'(bus.interrupt), 0);
        end
        step();
        chk("hold_expired", int'(bus.interrupt), 1);

        // Enable drop out of REQ, then re-enable with count=1
        bus.intr_en = 1'b0;
        step();
        chk("en_drop", int'(bus.interrupt), 0);
        step();
        chk("en_idle", int'(bus.interrupt), 0);
        bus.intr_en = 1'b1;
        step();
        chk("en_again", int'(bus.interrupt), 1);

        // Into DRAIN with count=3, then async reset between edges
        bus.intr_ack = 1'b1;
        step();
        bus.intr_ack = 1'b0;
        chk("ar_ack", int'(bus.interrupt), 0);
        set_in(1'b1, 8'h66, 1'b0);
        step();
        set_in(1'b1, 8'h77, 1'b0);
        step();
        set_in(1'b0, 8'h00, 1'b0);
        chk("ar_pre_count", int'(bus.count), 3);
        chk("ar_pre_port", int'(bus.input_port), 8'h55);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_count", int'(bus.count), 0);
        chk("ar_port", int'(bus.input_port), 8'h00);
        chk("ar_ready", int'(bus.ext_ready), 1);
        chk("ar_intr", int'(bus.interrupt), 0);
        chk("ar_rderr", int'(bus.rd_err), 0);
        #1;
        reset = 1'b1;
        step();
        chk("ar_post_count", int'(bus.count), 0);
        chk("ar_post_intr", int'(bus.interrupt), 0);
        step();
        chk("ar_post_intr2", int'(bus.interrupt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/in_port_ctrl.md
Name: in_port_ctrl

Overview:
- Input-port controller directly upstream of the CPU.
- Accepts bytes from an external source over a valid/ready handshake and buffers them in a small FIFO.
- Presents the FIFO head on the CPU's 8-bit input_port bus, and the CPU's IN instruction pops it via a read strobe.
- Raises the CPU interrupt line when data is waiting, with acknowledge and re-arm hold-off so an ISR can drain the FIFO without being re-interrupted.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- HOLDOFF, 8, cycles after drain-to-empty before a new interrupt may be raised; 0 means immediate re-arm.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- ext_data  input  8  byte from external source.
- ext_valid  input  1  ext_data valid.
- ext_ready  output  1  FIFO can accept; equals !full.
- in_rd  input  1  CPU IN strobe; pops FIFO head at rising edge.
- input_port  output  8  FIFO head when non-empty, else 8'h00.
- intr_en  input  1  interrupt enable.
- interrupt  output  1  interrupt request to CPU, level.
- intr_ack  input  1  CPU acknowledge, one cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.
- rd_err  output  1  sticky; set by in_rd while empty.

Behaviour:
- Reset (reset=0, async):
  - Pointers and count are 0; FIFO storage is not cleared.
  - FSM goes to IDLE; hold-off counter is 0.
  - Outputs: ext_ready=1, input_port=8'h00, interrupt=0, count=0, rd_err=0.
  - Reset mid-transfer discards all buffered data. No push or pop occurs on the edge where reset deasserts if reset is still low at that edge.
- Push: ext_valid && ext_ready at the rising edge. Data is written at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: in_rd && !empty. rd_ptr advances and wraps modulo DEPTH.
- input_port is combinational from registered state. The new head is visible the cycle after a pop, with zero bubble.
- Simultaneous push and pop:
  - Neither full nor empty: both occur; count is unchanged.
  - Empty: push only; in_rd sets rd_err.
  - Full: pop only, because ext_ready=0. ext_ready rises the next cycle.
- ext_valid while full: no push and no drop. The source must hold the byte.
- Latency: a byte accepted at edge N appears on input_port after edge N (same cycle as count increment).
- rd_err: set on in_rd while empty; cleared only by reset.
- Interrupt FSM (state registered; interrupt is a registered output):
  - IDLE: interrupt=0. If intr_en && count!=0, go to REQ.
  - REQ: interrupt=1.
    - If intr_ack, go to DRAIN.
    - Else if !intr_en, go to IDLE.
    - intr_ack takes priority over !intr_en in the same cycle.
  - DRAIN: interrupt=0. When count==0 (including emptied by a pop this cycle), load the hold-off counter with HOLDOFF and go to HOLD. If HOLDOFF==0, go straight to IDLE.
  - HOLD: interrupt=0. Decrement the counter each cycle; at 1, go to IDLE. New pushes during HOLD do not shorten it.
  - intr_ack outside REQ is ignored.
- Interrupt timing: first push into an empty FIFO at edge N, with intr_en=1, puts the FSM in REQ at edge N+1, so interrupt is high after N+1.
- Implementation: flat RTL, single always block per register group, no latches.

Test Plan:
- Reset check: hold reset=0 with ext_valid=1 and ext_data=8'hAA -> ext_ready=1, count=0, input_port=8'h00, interrupt=0. Release, push 8'h11, 8'h22 -> input_port=8'h11, count=2.
- Full and wrap: push 8'h01..8'h04 (DEPTH=4) -> ext_ready=0, count=4. Hold ext_valid with 8'h05 -> not accepted. Pop once -> 8'h05 accepted next edge. Popping all yields 02,03,04,05 with the pointer wrapped.
- Simultaneous push and pop at count=2 -> count stays 2, order preserved. in_rd on an empty FIFO -> rd_err=1 and stays 1 through later pops.
- Interrupt flow: intr_en=1, push 8'h3C at edge N -> interrupt=1 after N+1. intr_ack -> interrupt=0. Push 2 more and pop all -> no interrupt during DRAIN or HOLD. Push at hold-off cycle 3 -> interrupt rises only after HOLD expires (cycle 8+1).
- Enable drop: FSM in REQ, intr_en->0 -> interrupt=0 next cycle, FSM in IDLE. Re-enable with count=1 -> interrupt=1 one cycle later.
- Async reset mid-operation: count=3, FSM in DRAIN, pulse reset=0 between edges -> outputs clear immediately without a clock edge. After release, count=0 and interrupt=0.
